ifu_sram_fetch: RTL and testbench



---
 rtl/ifu_pkg.sv | 20 ++
 rtl/ifu_fifo.sv | 52 +++++
 rtl/ifu_sram_fetch.sv | 129 ++++++++++++
 tb/tb_ifu_sram_fetch.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  localparam logic [1:0] INST_SIZE_WORD = 2'd2;
  localparam int         INST_W         = 32;
  localparam int         ADDR_W         = 64;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic              misalign;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with flush; flush overrides push and pop in the same cycle.
module ifu_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       head
);

  localparam int              PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0]  DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = count == DEPTH_C;
  assign empty   = count == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/ifu_sram_fetch.sv
// Sequential instruction fetch over an sram-like port, one request in flight, buffered for decode.
// Optional: define IFU_MISALIGN_CHECK_EN to turn misaligned PCs into a marker entry instead of a fetch.
module ifu_sram_fetch
  import ifu_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [63:0] inst_addr,
  output logic [63:0] inst_wdata,
  input  logic [63:0] inst_rdata,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_misalign
);

  localparam int              CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] pc, req_pc;
  logic [CNT_W-1:0]  count;
  logic              full, empty, credit, handshake, push, pop;
  logic              misalign, halted, mark, unused_full;
  logic [INST_W-1:0] word;
  fetch_entry_t      push_entry, head;

  // The only outstanding request never exists in IDLE, so a free slot covers its response.
  assign credit = count < DEPTH_C;

`ifdef IFU_MISALIGN_CHECK_EN
  assign misalign = pc[1:0] != 2'b00;
`else
  assign misalign = 1'b0;
`endif

  assign mark      = state == IDLE && misalign && credit && !halted;
  assign inst_req  = !reset && state == IDLE && credit && !misalign;
  assign handshake = inst_req && inst_addr_ok;
  assign word      = req_pc[2] ? inst_rdata[63:32] : inst_rdata[31:0];
  assign push      = !redirect_valid && (mark || (state == WAIT && inst_data_ok));
  assign pop       = out_valid && out_ready && !redirect_valid;

  always_comb begin
    push_entry.pc       = req_pc;
    push_entry.inst     = word;
    push_entry.misalign = 1'b0;
    if (mark) begin
      push_entry.pc       = pc;
      push_entry.inst     = '0;
      push_entry.misalign = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (handshake)    state_nxt = WAIT;
      WAIT:    if (inst_data_ok) state_nxt = IDLE;
      DROP:    if (inst_data_ok) state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
    // A response still owed by the bridge must be swallowed after a redirect.
    if (redirect_valid) begin
      if ((state == IDLE && handshake) || (state != IDLE && !inst_data_ok)) state_nxt = DROP;
      else                                                                   state_nxt = IDLE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      halted <= 1'b0;
    end else begin
      state <= state_nxt;
      if (redirect_valid) begin
        pc     <= redirect_pc;
        halted <= 1'b0;
      end else begin
        if (handshake) pc     <= pc + 64'd4;
        if (mark)      halted <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (handshake) req_pc <= pc;
  end

  ifu_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .data  (push_entry),
    .full  (full),
    .empty (empty),
    .count (count),
    .head  (head)
  );

  assign unused_full  = full;
  assign out_valid    = !empty;
  assign out_pc       = out_valid ? head.pc : '0;
  assign out_inst     = out_valid ? head.inst : '0;
  assign out_misalign = out_valid && head.misalign;

  assign inst_wr    = 1'b0;
  assign inst_size  = INST_SIZE_WORD;
  assign inst_addr  = pc;
  assign inst_wdata = '0;

endmodule

// File: tb/tb_ifu_sram_fetch.sv
// Randomized bench: a bridge model with variable latency, and a decode-side model that expects
// a gap-free PC stream restarting at every redirect target.
module tb_ifu_sram_fetch;

  localparam logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000;
  localparam int          FIFO_DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [63:0] inst_addr, inst_wdata;
  logic [63:0] inst_rdata = '0;
  logic        inst_addr_ok = 1'b0, inst_data_ok = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        out_misalign;

  int          n_checks = 0, n_errors = 0;
  logic [63:0] exp_pc = RESET_PC;
  bit          pend = 1'b0;
  int          cnt = 0;
  logic [63:0] pend_addr = '0;
  bit          prev_stall = 1'b0;
  logic [63:0] prev_addr = '0;
  int          pops = 0;
  int          lat_lo = 2, lat_hi = 6;
  bit          chk_empty = 1'b0, exp_mis = 1'b0;

  always #5 clock = ~clock;

  ifu_sram_fetch #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_req       (inst_req),
    .inst_wr        (inst_wr),
    .inst_size      (inst_size),
    .inst_addr      (inst_addr),
    .inst_wdata     (inst_wdata),
    .inst_rdata     (inst_rdata),
    .inst_addr_ok   (inst_addr_ok),
    .inst_data_ok   (inst_data_ok),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_misalign   (out_misalign)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Memory contents: 32-bit word stored at a word-aligned address.
  function automatic logic [31:0] word_at(input logic [63:0] a);
    if (a == 64'h8000_0000) return 32'h1111_2222;
    if (a == 64'h8000_0004) return 32'hAAAA_BBBB;
    return (a[31:0] * 32'h9E37_79B9) ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [63:0] beat(input logic [63:0] a);
    logic [63:0] base;
    base = {a[63:3], 3'b000};
    return {word_at(base + 64'd4), word_at(base)};
  endfunction

  function automatic logic [63:0] pick_target();
    if ($urandom_range(0, 7) == 0) return 64'hFFFF_FFFF_FFFF_FFF0;
    return RESET_PC + {50'd0, 12'($urandom_range(0, 4095)), 2'b00};
  endfunction

  task automatic do_cycle(input int rdy_pct, input int acc_pct, input int redir_pct,
                          input bit force_redir, input logic [63:0] force_pc);
    bit dok, hs, redir;
    @(negedge clock);
    check("const_outs", {61'd0, inst_wr, inst_size}, 64'd2);
    check("wdata", inst_wdata, 64'd0);
    check("misalign_flag", 64'(out_misalign), 64'(exp_mis && out_valid));
    if (pend) check("req_while_pending", 64'(inst_req), 64'd0);
    if (prev_stall) begin
      check("req_held", 64'(inst_req), 64'd1);
      check("addr_held", inst_addr, prev_addr);
    end
    if (chk_empty) check("valid_after_flush", 64'(out_valid), 64'd0);

    dok = 1'b0;
    if (pend) begin
      cnt--;
      dok = (cnt == 0);
    end
    inst_data_ok = dok;
    inst_rdata   = dok ? beat(pend_addr) : {$urandom, $urandom};
    inst_addr_ok = !pend && (int'($urandom_range(0, 99)) < acc_pct);
    hs           = inst_req && inst_addr_ok;
    out_ready    = int'($urandom_range(0, 99)) < rdy_pct;
    redir        = force_redir;
    if (!force_redir && redir_pct > 0)
      redir = int'($urandom_range(0, 99)) < ((dok || hs) ? 10 : redir_pct);
    redirect_valid = redir;
    redirect_pc    = force_redir ? force_pc : pick_target();

    if (out_valid && out_ready && !redir) begin
      check("pop_pc", out_pc, exp_pc);
      check("pop_inst", 64'(out_inst), 64'(word_at({exp_pc[63:2], 2'b00})));
      exp_pc = exp_pc + 64'd4;
      pops++;
    end
    if (redir) exp_pc = redirect_pc;
    if (dok) pend = 1'b0;
    if (hs) begin
      pend      = 1'b1;
      cnt       = int'($urandom_range(lat_lo, lat_hi));
      pend_addr = inst_addr;
    end
    prev_stall = inst_req && !inst_addr_ok && !redir;
    prev_addr  = inst_addr;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    inst_addr_ok   = 1'b0;
    inst_data_ok   = 1'b0;
    out_ready      = 1'b0;
    #1;
    check("rst_req", 64'(inst_req), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_pc", out_pc, 64'd0);
    check("rst_inst", 64'(out_inst), 64'd0);
    check("rst_misalign", 64'(out_misalign), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    exp_pc    = RESET_PC;
    pend      = 1'b0;
    chk_empty = 1'b0;
    exp_mis   = 1'b0;
    #1;
    check("first_req", 64'(inst_req), 64'd1);
    check("first_addr", inst_addr, RESET_PC);
    // Stray response with nothing outstanding must be ignored.
    inst_data_ok = 1'b1;
    inst_rdata   = {$urandom, $urandom};
    prev_stall   = 1'b1;
    prev_addr    = RESET_PC;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && pend; i++) do_cycle(100, 0, 0, 1'b0, '0);
    check("idle_reached", 64'(pend), 64'd0);
  endtask

  initial begin
    int p0;
    do_reset();

    // Decode stalls: the buffer fills to capacity and fetch stops.
    lat_lo = 2; lat_hi = 3;
    for (int i = 0; i < 40; i++) do_cycle(0, 100, 0, 1'b0, '0);
    check("full_no_req", 64'(inst_req), 64'd0);
    check("full_valid", 64'(out_valid), 64'd1);
    check("full_next_addr", inst_addr, RESET_PC + 64'h10);
    p0 = pops;
    for (int i = 0; i < 10; i++) do_cycle(100, 0, 0, 1'b0, '0);
    check("drain_count", 64'(pops - p0), 64'd4);
    check("resume_req", 64'(inst_req), 64'd1);
    check("resume_addr", inst_addr, RESET_PC + 64'h10);

    // Redirect while waiting; stale response arrives three cycles later.
    lat_lo = 4; lat_hi = 4;
    wait_idle();
    for (int i = 0; i < 10 && !pend; i++) do_cycle(100, 100, 0, 1'b0, '0);
    check("wait_hs", 64'(pend), 64'd1);
    do_cycle(100, 0, 0, 1'b1, 64'h8000_1000);
    chk_empty = 1'b1;
    for (int i = 0; i < 10 && pend; i++) do_cycle(100, 100, 0, 1'b0, '0);
    check("stale_dropped", 64'(pend), 64'd0);
    do_cycle(100, 100, 0, 1'b0, '0);
    check("refetch_req", 64'(inst_req), 64'd1);
    check("refetch_addr", inst_addr, 64'h8000_1000);
    for (int i = 0; i < 10 && pend; i++) do_cycle(100, 100, 0, 1'b0, '0);
    chk_empty = 1'b0;
    for (int i = 0; i < 10; i++) do_cycle(100, 100, 0, 1'b0, '0);

    // Misaligned redirect target.
    lat_lo = 2; lat_hi = 3;
    wait_idle();
    do_cycle(0, 0, 0, 1'b1, 64'h8000_0002);
`ifdef IFU_MISALIGN_CHECK_EN
    exp_mis = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_cycle(0, 100, 0, 1'b0, '0);
      check("mis_no_req", 64'(inst_req), 64'd0);
    end
    check("mis_valid", 64'(out_valid), 64'd1);
    check("mis_pc", out_pc, 64'h8000_0002);
    check("mis_inst", 64'(out_inst), 64'd0);
    do_cycle(0, 0, 0, 1'b1, RESET_PC + 64'h100);
    exp_mis = 1'b0;
`else
    do_cycle(0, 0, 0, 1'b0, '0);
    check("mis_req", 64'(inst_req), 64'd1);
    check("mis_addr", inst_addr, 64'h8000_0002);
    for (int i = 0; i < 12; i++) do_cycle(100, 100, 0, 1'b0, '0);
    do_cycle(0, 0, 0, 1'b1, RESET_PC + 64'h100);
`endif

    // Random traffic with redirects, bridge stalls, and one reset mid-stream.
    lat_lo = 2; lat_hi = 6;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      do_cycle(70, 60, 4, 1'b0, '0);
    end
    check("progress", 64'(pops > 150), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
